// File: rtl/position_sweeper_pkg.sv
// position_sweeper_pkg
// Shared types and helpers for the vertical position sweeper.
//   state_t    : sweeper FSM states (ST_DWELL is used only when
//                POSITION_SWEEPER_DWELL_EN is defined)
//   clamp_step : one saturating step of a coordinate toward hi or lo
package position_sweeper_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  // Moves cur by step toward hi (up) or toward lo (dn), then saturates.
  // Both or neither direction holds cur. The sum and difference carry one
  // extra bit, so neither an overflow past hi nor a borrow below zero can
  // wrap around. Callers zero-extend narrower coordinates into 32 bits.
  function automatic logic [31:0] clamp_step(
    input logic [31:0] cur,
    input logic [31:0] step,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input logic        up,
    input logic        dn
  );
    logic [32:0] sum;
    logic [32:0] dif;
    sum = {1'b0, cur} + {1'b0, step};
    dif = {1'b0, cur} - {1'b0, step};
    clamp_step = cur;
    if (up && !dn) begin
      clamp_step = (sum > {1'b0, hi}) ? hi : sum[31:0];
    end else if (dn && !up) begin
      // dif[32] is the borrow: cur - step went below zero
      clamp_step = (dif[32] || (dif[31:0] < lo)) ? lo : dif[31:0];
    end
  endfunction

endpackage

// File: rtl/position_sweeper_if.sv
// position_sweeper_if
// Bundles the sweeper's direction inputs and position outputs.
//   enable   : advance the divider / position when high
//   increase : move down (pos grows)
//   decrease : move up (pos shrinks)
//   pos      : current Y coordinate
//   high     : pos is at the top limit
//   low      : pos is at the bottom limit
//   tick     : one-cycle pulse when a new pos value appears
// master : the side that drives direction/enable (direction logic, bench)
// slave  : the sweeper itself
interface position_sweeper_if #(
  parameter int WIDTH = 7
);
  logic             enable;
  logic             increase;
  logic             decrease;
  logic [WIDTH-1:0] pos;
  logic             high;
  logic             low;
  logic             tick;

  modport master (
    output enable, increase, decrease,
    input  pos, high, low, tick
  );

  modport slave (
    input  enable, increase, decrease,
    output pos, high, low, tick
  );
endinterface

// File: rtl/rate_divider.sv
// rate_divider
// Enable-gated down-counter that emits a one-cycle strobe every DIV
// enabled cycles. Shared by the game timing blocks.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; counter restarts at DIV-1
//   enable : counter advances only while high; otherwise it freezes
//   strobe : high in the enabled cycle where the counter reads 0
module rate_divider #(
  parameter int DIV = 833333
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic strobe
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the consumer registers its update on the same edge
  // that reloads the counter.
  assign strobe = enable && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= RELOAD;
    end else if (enable) begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/position_sweeper.sv
// position_sweeper
// Saturating Y-coordinate generator for the bounce loop. Steps pos by
// STEP rows on every divider strobe in the direction given by
// increase/decrease, clamps to [MIN, MAX] and reports the limits back to
// the direction flip-flop through high/low. Y grows downward.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; highest priority
//   bus   : position_sweeper_if.slave (enable, increase, decrease in;
//           pos, high, low, tick out, all outputs registered)
// Build option: define POSITION_SWEEPER_DWELL_EN to pause pos for DWELL
// strobes at every newly reached limit.
module position_sweeper
  import position_sweeper_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int MIN   = 0,
  parameter int MAX   = 119,
  parameter int START = 0,
  parameter int STEP  = 1,
  parameter int DIV   = 833333,
  parameter int DWELL = 4
) (
  input logic               clk,
  input logic               reset,
  position_sweeper_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);

  if (!((MIN < MAX) && (MAX < (1 << WIDTH)) && (MIN <= START) &&
        (START <= MAX) && (STEP >= 1) && (STEP <= MAX - MIN) &&
        (DIV >= 1) && (DWELL >= 1))) begin : g_bad_params
    $error("position_sweeper: illegal parameter combination");
  end

  logic             strobe;
  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] pos_nxt;
  logic             high_q;
  logic             low_q;
  logic             tick_q;
  state_t           state;

  rate_divider #(
    .DIV(DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(bus.enable),
    .strobe(strobe)
  );

  assign pos_nxt = WIDTH'(clamp_step(32'(pos_q), 32'(STEP), 32'(MIN),
                                     32'(MAX), bus.increase, bus.decrease));

`ifdef POSITION_SWEEPER_DWELL_EN
  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DWELL_LOAD = DCW'(DWELL - 1);

  logic [DCW-1:0] dwell_cnt;
  logic           new_limit;

  // Only arriving at a limit starts a dwell; a clamped step that was
  // already sitting on the limit does not.
  assign new_limit = ((pos_nxt == MIN_V) && (pos_q != MIN_V)) ||
                     ((pos_nxt == MAX_V) && (pos_q != MAX_V));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= START_V;
      high_q <= (START_V == MIN_V);
      low_q  <= (START_V == MAX_V);
      tick_q <= 1'b0;
      state  <= ST_RUN;
`ifdef POSITION_SWEEPER_DWELL_EN
      dwell_cnt <= '0;
`endif
    end else begin
      // tick marks every strobe, including holds and dwell strobes
      tick_q <= strobe;
      if (strobe) begin
        case (state)
          ST_RUN: begin
            // Flags come from the same next value so they never lag pos
            pos_q  <= pos_nxt;
            high_q <= (pos_nxt == MIN_V);
            low_q  <= (pos_nxt == MAX_V);
`ifdef POSITION_SWEEPER_DWELL_EN
            if (new_limit) begin
              state     <= ST_DWELL;
              dwell_cnt <= DWELL_LOAD;
            end
`endif
          end
          ST_DWELL: begin
`ifdef POSITION_SWEEPER_DWELL_EN
            // Direction is ignored here; the strobe that sees 0 only
            // returns to RUN and does not move.
            if (dwell_cnt == '0) state <= ST_RUN;
            else                 dwell_cnt <= dwell_cnt - 1'b1;
`else
            state <= ST_RUN;
`endif
          end
        endcase
      end
    end
  end

  assign bus.pos  = pos_q;
  assign bus.high = high_q;
  assign bus.low  = low_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_position_sweeper.sv
// tb_position_sweeper
// Directed bench for position_sweeper with MIN=0, MAX=10, START=0,
// STEP=3, DIV=4, DWELL=2. Expected positions are written out by hand;
// the dwell variant of the expectations is selected with
// POSITION_SWEEPER_DWELL_EN.
module tb_position_sweeper;

  localparam int WIDTH = 7;
  localparam int DIV   = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  position_sweeper_if #(.WIDTH(WIDTH)) bus ();

  position_sweeper #(
    .WIDTH(WIDTH),
    .MIN  (0),
    .MAX  (10),
    .START(0),
    .STEP (3),
    .DIV  (DIV),
    .DWELL(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed,
                     input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock, then settle past the edge before sampling or driving.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects tick low for DIV-1 cycles, then a tick carrying exp_pos with
  // flags matching the 0..10 limits.
  task automatic next_tick(input string tag, input int exp_pos);
    for (int i = 0; i < DIV - 1; i++) begin
      cyc();
      chk({tag, ".gap_tick"}, 32'(bus.tick), 32'd0);
    end
    cyc();
    chk({tag, ".tick"}, 32'(bus.tick), 32'd1);
    chk({tag, ".pos"},  32'(bus.pos),  32'(exp_pos));
    chk({tag, ".high"}, 32'(bus.high), (exp_pos == 0)  ? 32'd1 : 32'd0);
    chk({tag, ".low"},  32'(bus.low),  (exp_pos == 10) ? 32'd1 : 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pos"},  32'(bus.pos),  32'd0);
    chk({tag, ".high"}, 32'(bus.high), 32'd1);
    chk({tag, ".low"},  32'(bus.low),  32'd0);
    chk({tag, ".tick"}, 32'(bus.tick), 32'd0);
  endtask

`ifdef POSITION_SWEEPER_DWELL_EN
  int loop_exp[$] = '{1, 0, 0, 0, 3, 6, 9, 10, 10, 10, 7, 4, 1, 0, 0, 0, 3};
`else
  int loop_exp[$] = '{1, 0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
`endif

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.increase = 1'b0;
    bus.decrease = 1'b0;

    // Power-on reset
    cyc();
    cyc();
    chk_reset_state("por");

    // Ramp down to 6, then both/neither directions hold with a tick
    reset        = 1'b0;
    bus.enable   = 1'b1;
    bus.increase = 1'b1;
    next_tick("ramp0", 3);
    next_tick("ramp0", 6);
    bus.decrease = 1'b1;
    next_tick("both", 6);
    bus.increase = 1'b0;
    bus.decrease = 1'b0;
    next_tick("neither", 6);

    // Mid-run reset at pos=6; divider restarts from DIV-1
    bus.increase = 1'b1;
    cyc();
    reset = 1'b1;
    cyc();
    chk_reset_state("midreset");
    reset = 1'b0;

    // Ramp to the bottom limit and clamp there
    next_tick("ramp1", 3);
    next_tick("ramp1", 6);
    next_tick("ramp1", 9);
    next_tick("ramp1", 10);
    next_tick("hold10", 10);
`ifdef POSITION_SWEEPER_DWELL_EN
    next_tick("dwell10", 10);
`endif
    bus.increase = 1'b0;
    bus.decrease = 1'b1;
    next_tick("leave10", 7);

    // Enable gap two cycles after a tick: divider resumes mid-count
    cyc();
    chk("pregap.tick", 32'(bus.tick), 32'd0);
    cyc();
    chk("pregap.tick", 32'(bus.tick), 32'd0);
    bus.enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("gap.tick", 32'(bus.tick), 32'd0);
      chk("gap.pos",  32'(bus.pos),  32'd7);
    end
    bus.enable = 1'b1;
    cyc();
    chk("resume.tick", 32'(bus.tick), 32'd0);
    cyc();
    chk("resume.tick", 32'(bus.tick), 32'd1);
    chk("resume.pos",  32'(bus.pos),  32'd4);

    // Closed loop: direction flip-flop model reacts to high/low
    foreach (loop_exp[k]) begin
      next_tick("loop", loop_exp[k]);
      chk("loop.range", (32'(bus.pos) <= 32'd10) ? 32'd1 : 32'd0, 32'd1);
      if (bus.low) begin
        bus.increase = 1'b0;
        bus.decrease = 1'b1;
      end else if (bus.high) begin
        bus.increase = 1'b1;
        bus.decrease = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/position_sweeper.md
# position_sweeper

Vertical position generator that sits on the other side of the direction flip-flop. It consumes the `increase`/`decrease` direction levels, steps a saturating Y coordinate at a divided-down rate, and reports `high` (top limit reached) and `low` (bottom limit reached) back to the flip-flop, closing the bounce loop. Y grows downward, matching VGA row order, so `high` means `pos == MIN`. Its output feeds the sprite/obstacle drawing logic.

## Interface
- `WIDTH`, 7: position width in bits.
- `MIN`, 0: top limit; `high` is asserted here.
- `MAX`, 119: bottom limit; `low` is asserted here. Requires `MIN < MAX < 2**WIDTH`.
- `START`, 0: reset position. Must satisfy `MIN <= START <= MAX`.
- `STEP`, 1: rows moved per tick, with `1 <= STEP <= MAX-MIN`.
- `DIV`, 833333: enabled clock cycles per tick, `DIV >= 1`.
- `DWELL`, 4: ticks held at a limit. Used only when dwell is compiled in.

Ports:
- `clk` in, 1 bit: single clock. All logic is on the rising edge.
- `reset` in, 1 bit: synchronous, active-high. Takes priority over all other inputs.
- `enable` in, 1 bit: when low, the divider, position and dwell counter are all frozen.
- `increase` in, 1 bit: move down (`pos` grows).
- `decrease` in, 1 bit: move up (`pos` shrinks).
- `pos` out, WIDTH bits: current Y coordinate, registered.
- `high` out, 1 bit: registered. Equals 1 iff `pos == MIN`.
- `low` out, 1 bit: registered. Equals 1 iff `pos == MAX`.
- `tick` out, 1 bit: one-cycle pulse. Asserted in the cycle in which the new `pos` first appears, whether or not `pos` actually changed.

## Operation
- **Reset values:** `pos = START`, `high = (START == MIN)`, `low = (START == MAX)`, `tick = 0`, divider = `DIV-1`, state = RUN, dwell count = 0.
- **Divider:**
  - Decrements only while `enable` is high.
  - When it reads 0 with `enable` high, it reloads `DIV-1` and fires an internal step strobe.
  - With `DIV = 1`, the strobe fires every enabled cycle.
- **Step in state RUN:**
  - `increase & !decrease`: `pos = min(pos+STEP, MAX)`.
  - `decrease & !increase`: `pos = max(pos-STEP, MIN)`.
  - Both inputs high, or neither: `pos` holds, but `tick` still pulses.
  - Arithmetic is done in WIDTH+1 bits before clamping, so no wrap-around is possible.
- **Flag update:** `high` and `low` are recomputed from the next value of `pos` and registered together with it. They never disagree with `pos` in any cycle.
- **States:**
  - RUN: normal stepping as above.
  - DWELL: present only when dwell is compiled in.
- **Transitions:**
  - RUN → DWELL on a step whose result equals MIN or MAX, when the previous `pos` was not at that limit. Dwell count loads `DWELL-1`.
  - DWELL: each strobe pulses `tick` and leaves `pos` unchanged. The count decrements on each strobe. On the strobe where the count reads 0, the state returns to RUN and that strobe does not move.
  - In DWELL, `increase`/`decrease` are ignored.
- **Mid-operation reset:** returns everything to the reset values in the following cycle, including during DWELL.
- **Enable deassertion:** holds all state and keeps `tick` at 0. Resuming `enable` continues the divider count exactly where it stopped.

## Timing
- A strobe in cycle N produces the updated `pos`/`high`/`low` with `tick = 1` in cycle N+1.
- Latency from `increase`/`decrease` to an effect is the next strobe. The inputs are sampled in the strobe cycle only.
- Direction loop:
  - `low` rises in cycle N+1.
  - The direction flip-flop flips in N+2.
  - The next strobe, at least `DIV` cycles later, moves in the new direction.
  - With `DIV = 1`, exactly one extra clamped step occurs at the limit; it holds `pos`.
- Throughput: at most one step per `DIV` enabled cycles.

## Configuration
- Macro: `POSITION_SWEEPER_DWELL_EN`.
- Defined:
  - The DWELL state and its counter exist.
  - `pos` pauses for `DWELL` strobes at each newly reached limit.
- Undefined:
  - The FSM is RUN only and the `DWELL` parameter is ignored.
  - The limit is left on the first strobe after the direction changes.

## Structure
- `position_sweeper_pkg` holds:
  - the state enum (`ST_RUN`, `ST_DWELL`);
  - the clamp helper function (WIDTH+1 bit add/sub with saturation).
- Sub-module `rate_divider`:
  - parameter `DIV`;
  - ports `clk`, `reset`, `enable`, `strobe`;
  - reused by other game timing blocks.
- The top level contains the FSM, position register and flag registers.

## Test plan
Bench parameters: `MIN=0`, `MAX=10`, `START=0`, `STEP=3`, `DIV=4`, `DWELL=2`.
1. **Reset:** assert `reset` mid-run at `pos = 6` → next cycle `pos = 0`, `high = 1`, `low = 0`, `tick = 0`, and the divider restarts with the first tick 4 enabled cycles later.
2. **Ramp down, no dwell, `increase` held:** `pos` goes 3, 6, 9, 10 on successive ticks 4 cycles apart. `low = 1` from the tick showing 10; the next tick holds 10.
3. **Closed loop with a `directionff` model:** `pos` bounces 0 → 10 → 7 … 1 → 0 → 3. `high`/`low` assert exactly at 0/10. `pos` is never outside 0..10.
4. **Dwell compiled in:** on reaching 10, the next 2 ticks hold `pos = 10` with `tick` pulsing. The third tick, with `decrease = 1`, gives `pos = 7`.
5. **Both or neither:** `increase = decrease = 1` at `pos = 6` → `tick` pulses and `pos` stays 6. The same holds for both low.
6. **Enable gap:** drop `enable` for 7 cycles two cycles after a tick → no `tick` during the gap. The next tick comes 2 enabled cycles after resuming.
